// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry packetizer: FSM states,
// encoder header bytes, default channel width and the checksum step.
package telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    CKSUM = 2'd3
  } state_t;

  localparam logic [7:0] L_ENC_HDR    = 8'hFD;
  localparam logic [7:0] R_ENC_HDR    = 8'hFE;
  localparam int         DEF_CH_BYTES = 2;

  function automatic logic [7:0] cksum_update(input logic [7:0] acc,
                                              input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/telemetry_packetizer.sv
// Snapshots NUM_CH channel words on a trigger and streams them as headered,
// MSB-first byte frames (optional XOR checksum) over a valid/ready link.
module telemetry_packetizer
  import telemetry_pkg::*;
#(
  parameter int         NUM_CH   = 2,
  parameter int         CH_BYTES = DEF_CH_BYTES,
  parameter int         SRC_W    = 24,
  parameter logic [7:0] HDR_BASE = L_ENC_HDR,
  parameter bit         CKSUM_EN = 1'b1
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_n,
  input  logic                    i_trigger,
  input  logic [NUM_CH*SRC_W-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  output logic [7:0]              o_tx_byte,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic [7:0]              o_frame_cnt
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SNAP_W = NUM_CH * CH_BYTES * 8;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ch, first_ch, next_ch;
  logic              next_found;
  logic [1:0]        idx;
  logic [SNAP_W-1:0] snap;
  logic [NUM_CH-1:0] mask;
  logic [7:0]        cksum;
  logic              accept, start, last_byte;
  logic              unused_src;

  // Source bits above the transmitted bytes are intentionally dropped.
  assign unused_src = ^i_ch_data;

  assign accept = o_tx_valid & i_tx_ready;
  assign start  = (state == IDLE) && i_trigger && (i_ch_mask != '0);

  // Lowest enabled channel for a new frame, and next enabled one after ch.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_ch_mask[i]) first_ch = CH_W'(i);
      if (mask[i] && (i > int'(ch))) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_tx_valid = (state != IDLE);
    o_busy     = (state != IDLE);
    o_tx_byte  = 8'h00;
    last_byte  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR: begin
        o_tx_byte = HDR_BASE + 8'(ch);
        if (accept) state_nxt = DATA;
      end
      DATA: begin
        o_tx_byte = snap[(int'(ch) * CH_BYTES + int'(idx)) * 8 +: 8];
        if (accept && (idx == 2'd0)) begin
          if (next_found) state_nxt = HDR;
          else if (CKSUM_EN) state_nxt = CKSUM;
          else begin
            state_nxt = IDLE;
            last_byte = 1'b1;
          end
        end
      end
      CKSUM: begin
        o_tx_byte = cksum;
        if (accept) begin
          state_nxt = IDLE;
          last_byte = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot is pure data: only written on frame start, never reset.
  always_ff @(posedge clk_100MHz) begin
    if (start) begin
      for (int c = 0; c < NUM_CH; c++)
        snap[c*CH_BYTES*8 +: CH_BYTES*8] <= i_ch_data[c*SRC_W +: CH_BYTES*8];
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      ch          <= '0;
      idx         <= '0;
      mask        <= '0;
      cksum       <= '0;
      o_overrun   <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_overrun <= i_trigger && (state != IDLE);
      if (start) begin
        ch    <= first_ch;
        mask  <= i_ch_mask;
        cksum <= '0;
      end else if (accept) begin
        cksum <= cksum_update(cksum, o_tx_byte);
        case (state)
          HDR:  idx <= 2'(CH_BYTES - 1);
          DATA: begin
            if (idx != 2'd0)    idx <= idx - 2'd1;
            else if (next_found) ch <= next_ch;
          end
          default: ;
        endcase
        if (last_byte) o_frame_cnt <= o_frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_packetizer.sv
// Directed bench for telemetry_packetizer: a checksum instance and a
// no-checksum instance share stimulus; expected bytes are hand-computed.
module tb_telemetry_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [47:0] data;
  logic [1:0]  mask;
  logic        ready;

  logic [7:0] byte0, cnt0, byte1, cnt1;
  logic       valid0, busy0, ovr0, valid1, busy1, ovr1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  telemetry_packetizer #(.NUM_CH(2), .CH_BYTES(2), .SRC_W(24),
                         .HDR_BASE(8'hFD), .CKSUM_EN(1'b1)) dut (
    .clk_100MHz(clk), .rst_n(rst_n), .i_trigger(trig), .i_ch_data(data),
    .i_ch_mask(mask), .o_tx_byte(byte0), .o_tx_valid(valid0),
    .i_tx_ready(ready), .o_busy(busy0), .o_overrun(ovr0), .o_frame_cnt(cnt0)
  );

  telemetry_packetizer #(.NUM_CH(2), .CH_BYTES(2), .SRC_W(24),
                         .HDR_BASE(8'hFD), .CKSUM_EN(1'b0)) dut_nock (
    .clk_100MHz(clk), .rst_n(rst_n), .i_trigger(trig), .i_ch_data(data),
    .i_ch_mask(mask), .o_tx_byte(byte1), .o_tx_valid(valid1),
    .i_tx_ready(ready), .o_busy(busy1), .o_overrun(ovr1), .o_frame_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Fire a trigger and check an n-byte frame (MSB-first in exp) at full rate.
  task automatic send_check(input string tag, input logic [63:0] exp,
                            input int n);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, {31'd0, valid0}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy0}, 32'd1);
      chk({tag, "_byte"}, {24'd0, byte0}, {24'd0, exp[(n-1-i)*8 +: 8]});
      @(negedge clk);
    end
    chk({tag, "_end_valid"}, {31'd0, valid0}, 32'd0);
    chk({tag, "_end_busy"}, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    logic [55:0] full;
    logic [47:0] full_nock;
    full      = 56'hFD_12_34_FE_AB_CD_43;
    full_nock = 48'hFD_12_34_FE_AB_CD;

    rst_n = 1'b0;
    trig  = 1'b0;
    data  = {24'h00ABCD, 24'h001234};
    mask  = 2'b11;
    ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_byte", {24'd0, byte0}, 32'h00);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_ovr", {31'd0, ovr0}, 32'd0);
    chk("rst_cnt", {24'd0, cnt0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame on both instances
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("full_valid", {31'd0, valid0}, 32'd1);
      chk("full_byte", {24'd0, byte0}, {24'd0, full[(6-i)*8 +: 8]});
      if (i < 6) chk("nock_byte", {24'd0, byte1}, {24'd0, full_nock[(5-i)*8 +: 8]});
      else       chk("nock_done", {31'd0, valid1}, 32'd0);
      @(negedge clk);
    end
    chk("full_end_valid", {31'd0, valid0}, 32'd0);
    chk("full_end_busy", {31'd0, busy0}, 32'd0);
    chk("full_cnt", {24'd0, cnt0}, 32'd1);
    chk("nock_cnt", {24'd0, cnt1}, 32'd1);

    // Masked channel 0
    mask = 2'b10;
    send_check("masked", 64'hFE_AB_CD_98, 4);
    chk("masked_cnt", {24'd0, cnt0}, 32'd2);
    mask = 2'b11;

    // Backpressure after header
    trig = 1'b1;
    @(negedge clk);
    trig  = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", {31'd0, valid0}, 32'd1);
      chk("bp_hold_byte", {24'd0, byte0}, 32'hFD);
      if (i == 2) ready = 1'b1;
      @(negedge clk);
    end
    for (int i = 1; i < 7; i++) begin
      chk("bp_byte", {24'd0, byte0}, {24'd0, full[(6-i)*8 +: 8]});
      @(negedge clk);
    end
    chk("bp_end_valid", {31'd0, valid0}, 32'd0);
    chk("bp_cnt", {24'd0, cnt0}, 32'd3);

    // Overrun mid-frame: snapshot must stay on first data
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("ovr_b0", {24'd0, byte0}, 32'hFD);
    @(negedge clk);
    chk("ovr_b1", {24'd0, byte0}, 32'h12);
    data = {24'h005566, 24'h007788};
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("ovr_pulse", {31'd0, ovr0}, 32'd1);
    chk("ovr_b2", {24'd0, byte0}, 32'h34);
    for (int i = 3; i < 7; i++) begin
      @(negedge clk);
      if (i == 3) chk("ovr_pulse_end", {31'd0, ovr0}, 32'd0);
      chk("ovr_byte", {24'd0, byte0}, {24'd0, full[(6-i)*8 +: 8]});
    end
    @(negedge clk);
    chk("ovr_end_busy", {31'd0, busy0}, 32'd0);
    chk("ovr_cnt", {24'd0, cnt0}, 32'd4);
    data = {24'h00ABCD, 24'h001234};

    // Trigger on the final-accept edge counts as overrun
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("fin_last_byte", {24'd0, byte0}, 32'h43);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("fin_ovr", {31'd0, ovr0}, 32'd1);
    chk("fin_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    chk("fin_ovr_end", {31'd0, ovr0}, 32'd0);
    chk("fin_idle", {31'd0, valid0}, 32'd0);
    chk("fin_cnt", {24'd0, cnt0}, 32'd5);

    // Reset mid-frame while 34 is presented
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_byte", {24'd0, byte0}, 32'h34);
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", {31'd0, valid0}, 32'd0);
    chk("rmid_busy", {31'd0, busy0}, 32'd0);
    chk("rmid_cnt", {24'd0, cnt0}, 32'd0);
    chk("rmid_obyte", {24'd0, byte0}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_check("after_rst", {8'h00, full}, 7);
    chk("after_rst_cnt", {24'd0, cnt0}, 32'd1);

    // Empty mask: no frame, no overrun
    mask = 2'b00;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("empty_valid", {31'd0, valid0}, 32'd0);
    chk("empty_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    chk("empty_ovr", {31'd0, ovr0}, 32'd0);
    chk("empty_cnt", {24'd0, cnt0}, 32'd1);
    mask = 2'b11;

    // Frame counter wrap: 255 more frames
    for (int f = 0; f < 255; f++) begin
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      repeat (7) @(negedge clk);
      if (f == 253) chk("wrap_ff", {24'd0, cnt0}, 32'hFF);
    end
    chk("wrap_zero", {24'd0, cnt0}, 32'h00);
    chk("wrap_idle", {31'd0, busy0}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/telemetry_packetizer.md
# telemetry_packetizer

Parametrised debug-telemetry framer that snapshots N channel words on a trigger and streams them as headered, MSB-first byte frames, with an optional XOR checksum, to a byte-wide UART transmitter through a valid/ready handshake. It sits between the motor controller's data-ready strobe, the encoder counters and `uart_tx`. It replaces the fixed two-channel, 16-bit encoder dump state machine. It adds the following beyond that machine:
- configurable channel count and bytes per channel;
- a per-channel enable mask;
- backpressure-safe handshaking;
- overrun detection.

## Interface
Parameters:
- NUM_CH, 2, number of channels (1..16)
- CH_BYTES, 2, bytes sent per channel (1..4)
- SRC_W, 24, width of each channel word; must be ≥ 8*CH_BYTES
- HDR_BASE, 8'hFD, header of channel 0; channel c header = HDR_BASE + c (mod 256)
- CKSUM_EN, 1, 1 = append checksum byte to each frame

Ports (one clock; reset is asynchronous and active-low):
- clk_100MHz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_trigger  in  1  single-cycle sample request
- i_ch_data  in  NUM_CH*SRC_W  channel words; channel c = bits [c*SRC_W +: SRC_W]
- i_ch_mask  in  NUM_CH  per-channel enable, sampled with data
- o_tx_byte  out  8  byte to transmitter
- o_tx_valid  out  1  o_tx_byte valid
- i_tx_ready  in  1  transmitter accepts byte this cycle
- o_busy  out  1  frame in progress
- o_overrun  out  1  one-cycle pulse: trigger dropped
- o_frame_cnt  out  8  completed frames, wraps at 256

## Operation
- States: IDLE, HDR, DATA, CKSUM.
- IDLE + i_trigger + mask≠0:
  - latch bits [8*CH_BYTES-1:0] of every channel and latch i_ch_mask;
  - clear checksum;
  - go to HDR for the lowest enabled channel.
- IDLE + i_trigger + mask=0: no frame, no overrun, stay IDLE.
- i_trigger in any state other than IDLE: ignored; o_overrun pulses for one cycle. The latched snapshot is unaffected.
- HDR: present HDR_BASE+c. On accept, go to DATA with byte index = CH_BYTES-1.
- DATA: present latched byte [idx] of channel c, MSB first. On accept:
  - if idx>0, decrement idx;
  - else go to HDR of the next enabled channel;
  - else, if none remain, go to CKSUM (CKSUM_EN=1) or IDLE.
- CKSUM: present the XOR of all bytes of the frame. On accept, go to IDLE.
- Every accepted byte is XORed into the checksum accumulator.
- Frame length = k*(1+CH_BYTES)+CKSUM_EN, where k = number of enabled channels.
- o_frame_cnt increments on acceptance of the final byte of a frame.

## Timing
- Accept = o_tx_valid & i_tx_ready on a rising clk_100MHz edge.
- Trigger sampled at edge n: o_tx_valid=1 and o_busy=1 from n+1, showing the first header.
- With i_tx_ready held high: one byte per cycle, no bubbles between channels or before the checksum.
- While o_tx_valid=1 and i_tx_ready=0: o_tx_byte and o_tx_valid are held stable. o_tx_valid never drops without an accept.
- Final byte accepted at edge m: o_tx_valid=0 and o_busy=0 from m+1. A trigger sampled at edge m counts as overrun, because the state is not IDLE at m.
- i_tx_ready while o_tx_valid=0: ignored.
- Reset values: o_tx_byte=8'h00, o_tx_valid=0, o_busy=0, o_overrun=0, o_frame_cnt=0, state IDLE.
- rst_n low mid-frame: immediate abort. Outputs go to reset values asynchronously. There is no partial frame resume, and the frame is not counted.

## Structure
- Shared package telemetry_pkg holds:
  - the state enum;
  - header constants L_ENC_HDR=8'hFD and R_ENC_HDR=8'hFE;
  - the default CH_BYTES;
  - the checksum function.
- A single module is natural. The byte select is an indexed part-select of the latched snapshot, so no sub-module is needed.

## Test plan
All scenarios use NUM_CH=2, CH_BYTES=2 and i_tx_ready=1 unless stated otherwise.
- Full frame: ch0=24'h001234, ch1=24'h00ABCD, mask=2'b11, trigger → bytes FD 12 34 FE AB CD 43 on 7 consecutive cycles; o_frame_cnt=1.
- Masked channel: mask=2'b10, same data → FE AB CD 98; o_busy for 4 cycles.
- Backpressure: drop i_tx_ready for 3 cycles after header FD → FD held with o_tx_valid=1 for all 3 cycles; stream resumes at 12 with no loss or duplication.
- Overrun: second trigger 2 cycles after the first → o_overrun pulses one cycle; the frame matches the first snapshot; o_frame_cnt=1. A trigger on the final-accept edge also pulses o_overrun.
- Reset mid-frame: rst_n low during byte 34 → o_tx_valid=0, o_busy=0, o_frame_cnt=0 asynchronously. The next trigger yields a full, correct 7-byte frame.
- Empty mask and wrap: mask=0 trigger → no output and no overrun. 256 frames → o_frame_cnt wraps to 0. CKSUM_EN=0 → 6-byte frame.
